flex_counter_updn: RTL

Parametrised up/down programmable counter, the next-generation flex counter for the datapath's timing and bit-count logic. It adds:
- direction control
- synchronous load
- optional saturation instead of wrap
- a one-cycle wrap pulse
- a saturating wrap-event counter with sticky overflow

It sits beside FSMs that need both bit/byte counting and "N wraps elapsed" status.

---
 rtl/flex_counter_updn.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/flex_counter_updn.sv
// rtl/flex_counter_updn.sv - up/down programmable counter with saturation, wrap pulse and wrap-event counter
//
// Purpose:
//   Programmable up/down counter for bit/byte counting beside control FSMs.
//   Supports direction control, synchronous load, optional saturation at the
//   terminal value, a one-cycle wrap pulse, and a saturating count of wrap
//   events with a sticky overflow bit.
//
// Ports:
//   clk            - system clock, all state on rising edge
//   rst            - asynchronous active-high reset
//   clear          - synchronous clear of all state (highest priority)
//   count_enable   - advance the counter this cycle
//   count_down     - 0 = count up, 1 = count down
//   load           - synchronous load of load_val
//   load_val       - value loaded into count_out
//   rollover_val   - terminal/top value; 0 disables counting
//   saturate       - 1 = hold at terminal instead of wrapping
//   count_out      - current count (registered)
//   rollover_flag  - registered; high while count_out equals current terminal
//   rollover_pulse - registered one-cycle pulse after each wrap event
//   wrap_count     - wrap events since reset/clear, saturating
//   wrap_count_ovf - sticky; set when a wrap occurs with wrap_count all ones

module flex_counter_updn #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     count_down,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic                     saturate,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic [NUM_WRAP_BITS-1:0] wrap_count,
    output logic                     wrap_count_ovf
);

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE = NUM_WRAP_BITS'(1);

    logic [NUM_CNT_BITS-1:0]  count_q, count_d;
    logic                     flag_q, flag_d;
    logic                     pulse_q, pulse_d;
    logic [NUM_WRAP_BITS-1:0] wrap_q, wrap_d;
    logic                     ovf_q, ovf_d;

    logic [NUM_CNT_BITS-1:0]  term;
    logic                     wrap_ev;
    logic                     cnt_active;

    // Terminal value depends on direction: top when counting up, 1 when down.
    assign term       = count_down ? CNT_ONE : rollover_val;
    assign cnt_active = (rollover_val != '0);

    always_comb begin
        count_d = count_q;
        flag_d  = 1'b0;
        pulse_d = 1'b0;
        wrap_d  = wrap_q;
        ovf_d   = ovf_q;
        wrap_ev = 1'b0;

        if (clear) begin
            count_d = '0;
            wrap_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (load) begin
                count_d = load_val;
            end else if (count_enable && cnt_active) begin
                if (!count_down) begin
                    // >= catches out-of-range loads; wrap lands on 1, never 0
                    if (count_q >= rollover_val) begin
                        if (!saturate) begin
                            count_d = CNT_ONE;
                            wrap_ev = 1'b1;
                        end
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    // <= 1 also treats the post-reset 0 as terminal
                    if (count_q <= CNT_ONE) begin
                        if (!saturate) begin
                            count_d = rollover_val;
                            wrap_ev = 1'b1;
                        end
                    end else if (count_q > rollover_val) begin
                        // Out-of-range value snaps to the top without a wrap
                        count_d = rollover_val;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            // Evaluated on every non-clear cycle so idle changes of direction
            // or rollover_val show up one cycle later, aligned with count_out.
            flag_d = cnt_active && (count_d == term);

            if (wrap_ev) begin
                pulse_d = 1'b1;
                if (&wrap_q) begin
                    ovf_d = 1'b1;
                end else begin
                    wrap_d = wrap_q + WRAP_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
            wrap_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out      = count_q;
    assign rollover_flag  = flag_q;
    assign rollover_pulse = pulse_q;
    assign wrap_count     = wrap_q;
    assign wrap_count_ovf = ovf_q;

endmodule
